// File: rtl/rf_writeback_queue_if.sv
// Writeback handshake bundle: execute-side result input and
// register-file write port output.
interface rf_writeback_queue_if #(
  parameter int XLEN = 64,
  parameter int XWDT = 6
);
  logic            in_valid;
  logic            in_ready;
  logic [XWDT-1:0] in_idx;
  logic [XLEN-1:0] in_data;
  logic [1:0]      in_size;
  logic [2:0]      in_pos;

  logic            wr_en;
  logic [XWDT-1:0] wr_idx;
  logic [XLEN-1:0] wr_data;
  logic [1:0]      wr_size;
  logic [2:0]      wr_pos;

  modport master (
    output in_valid, in_idx, in_data, in_size, in_pos,
    input  in_ready,
    input  wr_en, wr_idx, wr_data, wr_size, wr_pos
  );

  modport slave (
    input  in_valid, in_idx, in_data, in_size, in_pos,
    output in_ready,
    output wr_en, wr_idx, wr_data, wr_size, wr_pos
  );
endinterface

// File: rtl/rf_writeback_queue.sv
// In-order writeback FIFO feeding one register-file write port,
// with per-register pending-write hazard queries.
module rf_writeback_queue #(
  parameter int XLEN  = 64,
  parameter int XWDT  = 6,
  parameter int DEPTH = 4,
  parameter int NQ    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  rf_writeback_queue_if.slave     wb,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [NQ*XWDT-1:0]      q_idx,
  output logic [NQ-1:0]           q_busy,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XWDT-1:0] idx;
    logic [XLEN-1:0] data;
    logic [1:0]      size;
    logic [2:0]      pos;
  } wb_t;

  wb_t             mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   cnt_q;
  wb_t             out_q;
  logic            wr_en_q;
  logic            err_q;

  wb_t  in_ent;
  logic fire;
  logic legal;
  logic load;
  logic pop;
  logic bypass;
  logic enq;

  function automatic logic [XLEN-1:0] lane_mask(
    input logic [1:0] size
  );
    logic [XLEN-1:0] m;
    m = '0;
    for (int b = 0; b < XLEN; b++)
      if (b < (8 << size)) m[b] = 1'b1;
    return m;
  endfunction

  assign wb.in_ready = (cnt_q != CW'(DEPTH)) & !flush;
  assign fire  = wb.in_valid & wb.in_ready;
  assign legal = {1'b0, wb.in_pos} < (4'd8 >> wb.in_size);

  // The output slot may be refilled when empty or when its
  // write commits this edge, even while the rf is stalled.
  assign load   = !wr_en_q | !stall;
  assign pop    = load & (cnt_q != '0);
  assign bypass = load & (cnt_q == '0) & fire & legal;
  assign enq    = fire & legal & !bypass;

  always_comb begin
    in_ent      = '0;
    in_ent.idx  = wb.in_idx;
    in_ent.data = wb.in_data & lane_mask(wb.in_size);
    in_ent.size = wb.in_size;
    in_ent.pos  = wb.in_pos;
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= in_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt_q   <= '0;
      vld     <= '0;
      out_q   <= '0;
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt_q   <= '0;
      vld     <= '0;
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= fire & !legal;
      if (enq) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + AW'(1);
      end
      cnt_q <= cnt_q + CW'(enq) - CW'(pop);
      if (load) begin
        wr_en_q <= pop | bypass;
        if (pop)
          out_q <= mem[rd_ptr];
        else if (bypass)
          out_q <= in_ent;
      end
    end
  end

  always_comb begin
    logic [XWDT-1:0] qi;
    qi     = '0;
    q_busy = '0;
    for (int i = 0; i < NQ; i++) begin
      qi = q_idx[i*XWDT +: XWDT];
      if (wr_en_q && out_q.idx == qi)
        q_busy[i] = 1'b1;
      for (int j = 0; j < DEPTH; j++)
        if (vld[j] && mem[j].idx == qi)
          q_busy[i] = 1'b1;
    end
  end

  assign wb.wr_en   = wr_en_q;
  assign wb.wr_idx  = out_q.idx;
  assign wb.wr_data = out_q.data;
  assign wb.wr_size = out_q.size;
  assign wb.wr_pos  = out_q.pos;
  assign count      = cnt_q;
  assign err        = err_q;

endmodule
